// File: rtl/dwell_if.sv
// Request/response bundle between control logic and the dwell-limited output driver.
interface dwell_if;
    logic val_req;
    logic tick;
    logic val;
    logic rise;
    logic fall;
    logic pending;

    modport master (output val_req, output tick, input val, input rise, input fall, input pending);
    modport slave  (input val_req, input tick, output val, output rise, output fall, output pending);
endinterface

// File: rtl/dwell_driver.sv
// Drives a clean output level that never toggles faster than a minimum dwell,
// with single-cycle rise/fall event pulses on each change.
module dwell_driver #(
    parameter int   W         = 4,
    parameter int   MIN_HI    = 8,
    parameter int   MIN_LO    = 8,
    parameter logic RST_VAL   = 1'b1,
    parameter bit   WITH_TICK = 1'b0
) (
    input  logic    clk,
    input  logic    rst,
    dwell_if.slave  bus
);

    localparam int CNT_MAX = (1 << W) - 1;

    if (MIN_HI > CNT_MAX || MIN_LO > CNT_MAX || MIN_HI < 0 || MIN_LO < 0) begin : g_bad_min
        $error("dwell_driver: MIN_HI/MIN_LO must lie in 0..2^W-1");
    end

    localparam logic [W-1:0] MIN_HI_W = W'(MIN_HI);
    localparam logic [W-1:0] MIN_LO_W = W'(MIN_LO);

    logic         val_q, val_d;
    logic         rise_q, rise_d;
    logic         fall_q, fall_d;
    logic [W-1:0] cnt_q, cnt_d;

    logic         tick_i;
    logic [W-1:0] min_cur;
    logic         ok;
    logic         chg;

    always_comb begin
        val_d   = val_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        tick_i  = WITH_TICK ? bus.tick : 1'b1;
        min_cur = val_q ? MIN_HI_W : MIN_LO_W;
        ok      = (cnt_q >= min_cur);
        // The change decision ignores tick so a satisfied dwell passes on the very next clk.
        chg     = (bus.val_req != val_q) && ok;

        if (chg) begin
            val_d  = ~val_q;
            cnt_d  = '0;
            rise_d = ~val_q;
            fall_d = val_q;
        end else if (tick_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q  <= RST_VAL;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            val_q  <= val_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.val     = val_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.pending = (bus.val_req != val_q);

endmodule

// File: tb/tb_dwell_driver.sv
// Randomized and directed check of two dwell_driver configurations against a
// behavioural model that tracks elapsed dwell time since the last output change.
module tb_dwell_driver;

    logic clk;
    logic rst;

    dwell_if bus_a ();
    dwell_if bus_b ();

    dwell_driver #(.W(4), .MIN_HI(8), .MIN_LO(8), .RST_VAL(1'b1), .WITH_TICK(1'b0)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dwell_driver #(.W(4), .MIN_HI(3), .MIN_LO(2), .RST_VAL(1'b0), .WITH_TICK(1'b1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model state: index 0 = default config, index 1 = ticked config.
    int   m_min_hi [2] = '{8, 3};
    int   m_min_lo [2] = '{8, 2};
    logic m_rstv   [2] = '{1'b1, 1'b0};
    bit   m_wtick  [2] = '{1'b0, 1'b1};
    logic m_val    [2];
    int   m_elap   [2];
    logic m_rise   [2];
    logic m_fall   [2];
    logic m_req    [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Elapsed time only needs to be compared against a minimum <= 15, so an
    // unbounded (capped) tally is equivalent to a saturating counter.
    task automatic model_step(input int i, input logic r, input logic req, input logic tk);
        int need;
        need = m_val[i] ? m_min_hi[i] : m_min_lo[i];
        m_req[i] = req;
        if (r) begin
            m_val[i]  = m_rstv[i];
            m_elap[i] = 0;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
        end else if (req != m_val[i] && m_elap[i] >= need) begin
            m_rise[i] = ~m_val[i];
            m_fall[i] = m_val[i];
            m_val[i]  = ~m_val[i];
            m_elap[i] = 0;
        end else begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if ((!m_wtick[i] || tk) && m_elap[i] < 1000) m_elap[i]++;
        end
    endtask

    task automatic cyc(input logic r, input logic ra, input logic rb, input logic tk);
        rst           = r;
        bus_a.val_req = ra;
        bus_b.val_req = rb;
        bus_a.tick    = tk;
        bus_b.tick    = tk;
        @(posedge clk);
        model_step(0, r, ra, tk);
        model_step(1, r, rb, tk);
        #1;
        chk("a_val",     bus_a.val,     m_val[0]);
        chk("a_rise",    bus_a.rise,    m_rise[0]);
        chk("a_fall",    bus_a.fall,    m_fall[0]);
        chk("a_pending", bus_a.pending, m_req[0] != m_val[0]);
        chk("b_val",     bus_b.val,     m_val[1]);
        chk("b_rise",    bus_b.rise,    m_rise[1]);
        chk("b_fall",    bus_b.fall,    m_fall[1]);
        chk("b_pending", bus_b.pending, m_req[1] != m_val[1]);
    endtask

    int   n_cyc;
    logic tk4;

    initial begin
        int   fall_at;
        int   run_len;
        int   n_changes;
        int   n_pulses;
        logic prev_val;
        logic ra;
        logic rb;

        rst = 1'b1;
        bus_a.val_req = 1'b1; bus_b.val_req = 1'b0;
        bus_a.tick = 1'b0;    bus_b.tick = 1'b0;
        n_cyc = 0;

        // Reset, then a level request that matches the reset value.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_a_val", bus_a.val, 1'b1);
        chk("rst_b_val", bus_b.val, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            chk("hold_a_val", bus_a.val, 1'b1);
        end

        // Re-reset, release with request 0: fall expected in cycle 9.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        fall_at = -1;
        for (int c = 0; c < 15; c++) begin
            if (c == 0) begin
                // Cycle 0 is the first cycle after the last reset edge.
                chk("p2_pend0", bus_a.pending, 1'b1);
            end
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (bus_a.fall && fall_at < 0) fall_at = c + 1;
        end
        chk("p2_fall_cycle", fall_at, 9);

        // Saturated dwell: a single-cycle request passes with 1-cycle latency.
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("p3_val", bus_a.val, 1'b1);
        chk("p3_rise", bus_a.rise, 1'b1);

        // Go back to 0, then glitch the request during the dwell.
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("p4_at0", bus_a.val, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            ra = (c >= 2 && c <= 4);
            cyc(1'b0, ra, 1'b0, 1'b0);
            chk("p4_noch", bus_a.val, 1'b0);
        end

        // Toggle every clock: run lengths and pulse/change counts.
        prev_val = bus_a.val; run_len = 0; n_changes = 0; n_pulses = 0;
        for (int c = 0; c < 60; c++) begin
            cyc(1'b0, logic'(c[0]), 1'b0, 1'b0);
            run_len++;
            n_pulses += int'(bus_a.rise) + int'(bus_a.fall);
            if (bus_a.val != prev_val) begin
                if (n_changes > 0) chk("p5_runlen_ge9", run_len >= 9, 1'b1);
                n_changes++;
                run_len = 0;
                prev_val = bus_a.val;
            end
        end
        chk("p5_changes", n_changes > 3, 1'b1);
        chk("p5_pulses", n_pulses, n_changes);

        // Ticked config: tick every 4th clock, rise/fall/rise, then reset mid-dwell.
        for (int c = 0; c < 80; c++) begin
            tk4 = ((c % 4) == 3);
            rb  = (c < 20) || (c >= 40);
            cyc(1'b0, 1'b0, rb, tk4);
        end
        chk("p6_b_high", bus_b.val, 1'b1);
        for (int c = 0; c < 30; c++) cyc(1'b0, 1'b0, 1'b0, ((c % 4) == 3));
        chk("p6_b_low", bus_b.val, 1'b0);
        for (int c = 0; c < 5; c++) cyc(1'b0, 1'b0, 1'b1, ((c % 4) == 3));
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("p6_rst_val", bus_b.val, 1'b0);
        chk("p6_rst_rise", bus_b.rise, 1'b0);
        for (int c = 0; c < 20; c++) cyc(1'b0, 1'b0, 1'b1, ((c % 4) == 3));

        // Randomized: held requests, random ticks, occasional reset.
        ra = 1'b0; rb = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) ra = ~ra;
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            cyc(($urandom_range(0, 199) == 0), ra, rb, logic'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
